// File: rtl/shift_issue_stage.sv
// Shift-op issue stage: decodes RV32I shift ops on accept and queues them in a
// 2-entry in-order skid buffer feeding the shifter, with an illegal-op counter.
module shift_issue_stage #(
  parameter int size = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 funct3,
  input  logic                       funct7_5,
  input  logic                       is_imm,
  input  logic [size-1:0]            rs1_data,
  input  logic [size-1:0]            rs2_data,
  input  logic [$clog2(size)-1:0]    imm_shamt,
  input  logic [4:0]                 rd_addr,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [1:0]                 sel,
  output logic [$clog2(size)-1:0]    shamt,
  output logic [size-1:0]            data_out,
  output logic [4:0]                 rd_out,
  output logic                       illegal,
  output logic [15:0]                illegal_cnt
);

  localparam int SHW = $clog2(size);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  typedef struct packed {
    logic [1:0]      sel;
    logic [SHW-1:0]  shamt;
    logic [size-1:0] data;
    logic [4:0]      rd;
    logic            illegal;
  } entry_t;

  occ_t   occ;
  entry_t head;
  entry_t tail;
  entry_t dec;
  logic   accept;
  logic   pop;
  logic   rs2_unused;

  // Only the low SHW bits of rs2 ever reach the shifter.
  assign rs2_unused = &{1'b1, rs2_data[size-1:SHW]};

  always_comb begin
    dec         = '0;
    dec.data    = rs1_data;
    dec.rd      = rd_addr;
    dec.shamt   = is_imm ? imm_shamt : rs2_data[SHW-1:0];
    dec.illegal = 1'b0;
    if (funct3 == 3'b001 && !funct7_5) begin
      dec.sel = 2'b00;
    end else if (funct3 == 3'b101) begin
      dec.sel = funct7_5 ? 2'b11 : 2'b10;
    end else begin
      // Illegal ops become a zero-distance logical right shift: pass-through.
      dec.sel     = 2'b10;
      dec.shamt   = '0;
      dec.illegal = 1'b1;
    end
  end

  // in_ready is a pure function of occupancy, so no out_ready -> in_ready path.
  assign in_ready  = (occ != FULL);
  assign out_valid = (occ != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign sel      = head.sel;
  assign shamt    = head.shamt;
  assign data_out = head.data;
  assign rd_out   = head.rd;
  assign illegal  = head.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ         <= EMPTY;
      head        <= '0;
      tail        <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      occ <= EMPTY;
    end else begin
      if (accept && dec.illegal && illegal_cnt != 16'hFFFF) begin
        illegal_cnt <= illegal_cnt + 16'd1;
      end
      unique case (occ)
        EMPTY: begin
          if (accept) begin
            head <= dec;
            occ  <= ONE;
          end
        end
        ONE: begin
          if (accept && pop) begin
            head <= dec;
          end else if (accept) begin
            tail <= dec;
            occ  <= FULL;
          end else if (pop) begin
            occ <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head <= tail;
            occ  <= ONE;
          end
        end
        default: occ <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed bench for shift_issue_stage: decode, skid-buffer ordering, flush,
// illegal counting and asynchronous reset.
module tb_shift_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        is_imm;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  imm_shamt;
  logic [4:0]  rd_addr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  sel;
  logic [4:0]  shamt;
  logic [31:0] data_out;
  logic [4:0]  rd_out;
  logic        illegal;
  logic [15:0] illegal_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  shift_issue_stage #(.size(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .funct3(funct3), .funct7_5(funct7_5), .is_imm(is_imm),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm_shamt(imm_shamt),
    .rd_addr(rd_addr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .sel(sel), .shamt(shamt), .data_out(data_out),
    .rd_out(rd_out), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] f3, input logic f7, input logic imm,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic [4:0] ish, input logic [4:0] rd);
    funct3 = f3; funct7_5 = f7; is_imm = imm;
    rs1_data = r1; rs2_data = r2; imm_shamt = ish; rd_addr = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    set_op(3'b000, 1'b0, 1'b0, '0, '0, '0, '0);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if ({sel, shamt, data_out, rd_out, illegal} !== '0) begin n_bad++; $display("FAIL reset_head: got sel=%b shamt=%0d data=%h rd=%0d ill=%b want all 0", sel, shamt, data_out, rd_out, illegal); end
    n_cmp++; if (illegal_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_illegal_cnt: got %0d want 0", illegal_cnt); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_srai();
    set_op(3'b101, 1'b1, 1'b1, 32'h8000_00F0, 32'h0, 5'd4, 5'd7);
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL srai_valid: got %b want 1", out_valid); end
    n_cmp++; if (sel !== 2'b11) begin n_bad++; $display("FAIL srai_sel: got %b want 11", sel); end
    n_cmp++; if (shamt !== 5'd4) begin n_bad++; $display("FAIL srai_shamt: got %0d want 4", shamt); end
    n_cmp++; if (data_out !== 32'h8000_00F0) begin n_bad++; $display("FAIL srai_data: got %h want 800000f0", data_out); end
    n_cmp++; if (rd_out !== 5'd7) begin n_bad++; $display("FAIL srai_rd: got %0d want 7", rd_out); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL srai_illegal: got %b want 0", illegal); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL srai_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_sll_reg();
    set_op(3'b001, 1'b0, 1'b0, 32'h0000_00FF, 32'hFFFF_FFE3, 5'd17, 5'd12);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (shamt !== 5'd3) begin n_bad++; $display("FAIL sll_shamt: got %0d want 3", shamt); end
    n_cmp++; if (sel !== 2'b00) begin n_bad++; $display("FAIL sll_sel: got %b want 00", sel); end
    n_cmp++; if (rd_out !== 5'd12) begin n_bad++; $display("FAIL sll_rd: got %0d want 12", rd_out); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1;
    set_op(3'b001, 1'b0, 1'b1, 32'h1111_1111, 32'h0, 5'd1, 5'd1);
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready1: got %b want 1", in_ready); end
    set_op(3'b101, 1'b0, 1'b1, 32'h2222_2222, 32'h0, 5'd2, 5'd2);
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready2: got %b want 0", in_ready); end
    set_op(3'b101, 1'b1, 1'b1, 32'h3333_3333, 32'h0, 5'd3, 5'd3);
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_hold_ready: got %b want 0", in_ready); end
    n_cmp++; if ({out_valid, rd_out, sel, shamt, data_out} !== {1'b1, 5'd1, 2'b00, 5'd1, 32'h1111_1111}) begin n_bad++; $display("FAIL b2b_head_stable: got v=%b rd=%0d sel=%b sh=%0d d=%h want v=1 rd=1 sel=00 sh=1 d=11111111", out_valid, rd_out, sel, shamt, data_out); end
    n_cmp++; if (rd_out !== 5'd1) begin n_bad++; $display("FAIL b2b_pop1: got rd=%0d want 1", rd_out); end
    out_ready = 1'b1;
    step();
    n_cmp++; if ({out_valid, rd_out, sel, shamt, data_out} !== {1'b1, 5'd2, 2'b10, 5'd2, 32'h2222_2222}) begin n_bad++; $display("FAIL b2b_pop2: got v=%b rd=%0d sel=%b sh=%0d d=%h want v=1 rd=2 sel=10 sh=2 d=22222222", out_valid, rd_out, sel, shamt, data_out); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after_pop: got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, rd_out, sel, shamt, data_out} !== {1'b1, 5'd3, 2'b11, 5'd3, 32'h3333_3333}) begin n_bad++; $display("FAIL b2b_pop3: got v=%b rd=%0d sel=%b sh=%0d d=%h want v=1 rd=3 sel=11 sh=3 d=33333333", out_valid, rd_out, sel, shamt, data_out); end
    step();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    set_op(3'b000, 1'b0, 1'b1, 32'h1234_5678, 32'h0, 5'd7, 5'd9);
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, illegal, sel, shamt} !== {1'b1, 1'b1, 2'b10, 5'd0}) begin n_bad++; $display("FAIL ill_head: got v=%b ill=%b sel=%b sh=%0d want v=1 ill=1 sel=10 sh=0", out_valid, illegal, sel, shamt); end
    n_cmp++; if (data_out !== 32'h1234_5678) begin n_bad++; $display("FAIL ill_data: got %h want 12345678", data_out); end
    n_cmp++; if (illegal_cnt !== 16'd1) begin n_bad++; $display("FAIL ill_cnt_inc: got %0d want 1", illegal_cnt); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ill_flush_entry: got %b want 0", out_valid); end
    n_cmp++; if (illegal_cnt !== 16'd1) begin n_bad++; $display("FAIL ill_flush_cnt: got %0d want 1", illegal_cnt); end
    set_op(3'b001, 1'b1, 1'b1, 32'h0BAD_0BAD, 32'h0, 5'd9, 5'd4);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if ({illegal, sel, shamt, illegal_cnt} !== {1'b1, 2'b10, 5'd0, 16'd2}) begin n_bad++; $display("FAIL ill_sll_f7: got ill=%b sel=%b sh=%0d cnt=%0d want ill=1 sel=10 sh=0 cnt=2", illegal, sel, shamt, illegal_cnt); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_flush_full();
    in_valid = 1'b1; out_ready = 1'b0;
    set_op(3'b001, 1'b0, 1'b1, 32'hAAAA_0001, 32'h0, 5'd1, 5'd1);
    step();
    set_op(3'b001, 1'b0, 1'b1, 32'hAAAA_0002, 32'h0, 5'd2, 5'd2);
    step();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_pre_full: got %b want 0", in_ready); end
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL flush_full: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; out_ready = 1'b0;
    set_op(3'b101, 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0, 5'd5, 5'd5);
    step();
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_bad++; $display("FAIL arst_flags: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
    n_cmp++; if ({sel, shamt, data_out, rd_out, illegal, illegal_cnt} !== '0) begin n_bad++; $display("FAIL arst_outputs: got sel=%b sh=%0d d=%h rd=%0d ill=%b cnt=%0d want all 0", sel, shamt, data_out, rd_out, illegal, illegal_cnt); end
    step();
    rst_n = 1'b1;
    set_op(3'b001, 1'b0, 1'b1, 32'h0000_0F0F, 32'h0, 5'd8, 5'd21);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if ({out_valid, rd_out, shamt, data_out} !== {1'b1, 5'd21, 5'd8, 32'h0000_0F0F}) begin n_bad++; $display("FAIL arst_first_accept: got v=%b rd=%0d sh=%0d d=%h want v=1 rd=21 sh=8 d=00000f0f", out_valid, rd_out, shamt, data_out); end
  endtask

  initial begin
    test_reset();
    test_srai();
    test_sll_reg();
    test_back_to_back();
    test_illegal();
    test_flush_full();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_issue_stage.md
SHIFT_ISSUE_STAGE -- requirements
Module: shift_issue_stage

Interface
REQ-001 The block SHALL have parameter size, default 32, giving the data width.
REQ-002 The block SHALL have localparam SHW = $clog2(size), the shift-amount width (5 at default).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit, upstream decode offers an op.
REQ-006 The block SHALL have port in_ready, output, 1 bit, the block can accept an op.
REQ-007 The block SHALL have port funct3, input, 3 bits, RV32I funct3.
REQ-008 The block SHALL have port funct7_5, input, 1 bit, instruction bit 30.
REQ-009 The block SHALL have port is_imm, input, 1 bit, 1 selects the immediate shift amount, 0 selects rs2.
REQ-010 The block SHALL have port rs1_data, input, size bits, the operand to shift.
REQ-011 The block SHALL have port rs2_data, input, size bits, the register shift source.
REQ-012 The block SHALL have port imm_shamt, input, SHW bits, the immediate shift amount.
REQ-013 The block SHALL have port rd_addr, input, 5 bits, the destination register.
REQ-014 The block SHALL have port flush, input, 1 bit, a synchronous pipeline kill.
REQ-015 The block SHALL have port out_valid, output, 1 bit, the head entry is valid.
REQ-016 The block SHALL have port out_ready, input, 1 bit, the shifter/EX stage consumes the head.
REQ-017 The block SHALL have port sel, output, 2 bits, the shifter select.
REQ-018 The block SHALL have port shamt, output, SHW bits, the shifter amount.
REQ-019 The block SHALL have port data_out, output, size bits, the shifter operand (rs1).
REQ-020 The block SHALL have port rd_out, output, 5 bits, the destination register.
REQ-021 The block SHALL have port illegal, output, 1 bit, the head op is not a legal shift.
REQ-022 The block SHALL have port illegal_cnt, output, 16 bits, the count of accepted illegal ops.

Function
REQ-023 Decode SHALL be applied at accept time: funct3=001 with funct7_5=0 -> sel=00 (SLL); funct3=101 with funct7_5=0 -> sel=10 (SRL); funct3=101 with funct7_5=1 -> sel=11 (SRA); sel=01 SHALL never be produced.
REQ-024 Any other funct3/funct7_5 combination SHALL be stored with illegal=1, sel=10 and shamt=0, giving data pass-through.
REQ-025 For legal ops, shamt SHALL be imm_shamt when is_imm=1 and rs2_data[SHW-1:0] otherwise; the upper rs2 bits SHALL be ignored.
REQ-026 Storage SHALL be a 2-entry in-order skid buffer with an occupancy counter of 0..2.
REQ-027 An accept SHALL occur when in_valid and in_ready are both 1; a pop SHALL occur when out_valid and out_ready are both 1.
REQ-028 in_ready SHALL equal (count != 2) and SHALL depend on registered state only, with no combinational path from out_ready.
REQ-029 out_valid SHALL equal (count != 0); the outputs sel, shamt, data_out, rd_out and illegal SHALL come from the head entry and SHALL be driven from registers.
REQ-030 The latency from accept into an empty buffer to out_valid=1 SHALL be 1 cycle.
REQ-031 With out_ready held at 1, sustained throughput SHALL be 1 op per cycle.
REQ-032 A push and a pop in the same cycle at count=1 SHALL leave count=1, with the new op becoming the head.
REQ-033 A pop at count=2 SHALL promote the second entry to the head.
REQ-034 While out_valid=1 and out_ready=0, all head outputs SHALL remain stable.
REQ-035 flush=1 SHALL set count to 0 on the next edge and SHALL discard any op offered or popped in the same cycle; illegal_cnt SHALL NOT count a discarded op.
REQ-036 illegal_cnt SHALL increment on each accepted illegal op not discarded by flush, and SHALL saturate at 16'hFFFF.
REQ-037 Entry payloads SHALL be don't-care when the entry is invalid, but SHALL be X-free after reset.

Reset
REQ-038 When rst_n=0, the block SHALL asynchronously set count=0, out_valid=0, in_ready=1, sel=00, shamt=0, data_out=0, rd_out=0, illegal=0 and illegal_cnt=0.
REQ-039 Release of rst_n SHALL take effect at the next clk edge, and the block SHALL be able to accept an op in the first cycle after release.
REQ-040 Assertion of rst_n mid-stream SHALL drop all buffered ops with no further pop.

Verification
REQ-041 A bench SHALL cover: SRAI with rs1=32'h8000_00F0, imm_shamt=4, rd=7 into an empty buffer -> next cycle out_valid=1, sel=11, shamt=4, data_out=32'h8000_00F0, rd_out=7.
REQ-042 A bench SHALL cover: SLL with is_imm=0 and rs2=32'hFFFF_FFE3 -> shamt=5'd3, sel=00.
REQ-043 A bench SHALL cover: out_ready=0 with 3 back-to-back valid ops -> in_ready=0 after the 2nd accept, the 3rd op is held upstream, and the head stays op1; then out_ready=1 -> ops pop in order 1, 2, 3 on consecutive cycles.
REQ-044 A bench SHALL cover: funct3=000 accepted -> illegal=1, sel=10, shamt=0 and illegal_cnt increments 0->1; the same op offered with flush=1 -> no entry and illegal_cnt is unchanged.
REQ-045 A bench SHALL cover: count=2 with flush=1 and in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1.
REQ-046 A bench SHALL cover: rst_n pulsed low mid-cycle at count=2 -> out_valid=0 and all outputs are 0 immediately, without waiting for a clk edge.
